// File: rtl/agc_stim_seq_if.sv
// Control/status bundle for agc_stim_seq: start/abort, table write port and
// the AGC-facing clock, reset, stimulus pulses and sequencer status.
interface agc_stim_seq_if #(
    parameter int NCH   = 4,
    parameter int DEPTH = 8,
    parameter int TW    = 24,
    parameter int WW    = 8
);
    localparam int AW = $clog2(DEPTH);

    logic            start;
    logic            abort;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [TW-1:0]   wr_delay;
    logic [NCH-1:0]  wr_mask;
    logic [WW-1:0]   wr_width;
    logic            wr_last;
    logic            agc_clock;
    logic            agc_rst;
    logic [NCH-1:0]  pulse;
    logic            busy;
    logic            done;
    logic [AW-1:0]   evt_idx;

    modport master (
        output start, abort, wr_en, wr_addr, wr_delay, wr_mask, wr_width, wr_last,
        input  agc_clock, agc_rst, pulse, busy, done, evt_idx
    );

    modport slave (
        input  start, abort, wr_en, wr_addr, wr_delay, wr_mask, wr_width, wr_last,
        output agc_clock, agc_rst, pulse, busy, done, evt_idx
    );
endinterface

// File: rtl/agc_stim_seq.sv
// AGC stimulus sequencer: free-running AGC clock, timed reset hold, then a
// table of timed pulses. Optional macro SEQ_LOOP_EN repeats the table forever.
module agc_stim_seq #(
    parameter int NCH      = 4,
    parameter int DEPTH    = 8,
    parameter int TW       = 24,
    parameter int WW       = 8,
    parameter int CLKDIV   = 12,
    parameter int RST_HOLD = 250
) (
    input  logic          SIM_CLK,
    input  logic          SIM_RST_n,
    agc_stim_seq_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CLKDIV + 1);
    localparam int HW = $clog2(RST_HOLD + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HOLD  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_PULSE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    typedef struct packed {
        logic [TW-1:0]  delay;
        logic [NCH-1:0] mask;
        logic [WW-1:0]  width;
        logic           last;
    } entry_t;

    // Asserts asynchronously, releases on a clock edge two flops later.
    logic [1:0] rst_sync;
    logic       rst_n;
    always_ff @(posedge SIM_CLK or negedge SIM_RST_n) begin
        if (!SIM_RST_n) rst_sync <= 2'b00;
        else            rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    logic [CW-1:0] div_cnt;
    logic          clk_q;
    always_ff @(posedge SIM_CLK or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            clk_q   <= 1'b0;
        end else if (div_cnt == CW'(CLKDIV - 1)) begin
            div_cnt <= '0;
            clk_q   <= ~clk_q;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    logic [2:0]     state;
    logic [HW-1:0]  hold_cnt;
    logic [TW-1:0]  timer;
    logic [WW-1:0]  wcnt;
    logic [AW-1:0]  evt_idx;
    logic [NCH-1:0] pulse_q;
    logic           rst_q;
    logic           done_q;
    logic           busy;
    logic           wr_ok;

    entry_t             tbl [DEPTH];
    logic [DEPTH-1:0]   valid;
    entry_t             cur;
    entry_t             nxt;
    logic [AW-1:0]      nxt_idx;
    logic               seq_end;

    assign busy    = (state == S_HOLD) || (state == S_WAIT) || (state == S_PULSE);
    assign wr_ok   = bus.wr_en && !busy;
    assign cur     = tbl[evt_idx];
    assign nxt_idx = evt_idx + 1'b1;
    assign nxt     = tbl[nxt_idx];
    assign seq_end = cur.last || (evt_idx == AW'(DEPTH - 1)) || !valid[nxt_idx];

    // Table payload has no reset; only the valid bits are cleared.
    always_ff @(posedge SIM_CLK) begin
        if (wr_ok) tbl[bus.wr_addr] <= '{bus.wr_delay, bus.wr_mask, bus.wr_width, bus.wr_last};
    end

    always_ff @(posedge SIM_CLK or negedge rst_n) begin
        if (!rst_n)     valid <= '0;
        else if (wr_ok) valid[bus.wr_addr] <= 1'b1;
    end

    always_ff @(posedge SIM_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
            timer    <= '0;
            wcnt     <= '0;
            evt_idx  <= '0;
            pulse_q  <= '0;
            rst_q    <= 1'b1;
            done_q   <= 1'b0;
        end else if (bus.abort) begin
            state   <= S_IDLE;
            evt_idx <= '0;
            pulse_q <= '0;
            rst_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
`ifdef SEQ_LOOP_EN
            done_q <= 1'b0;
`endif
            case (state)
                S_IDLE, S_DONE: if (bus.start) begin
                    state    <= S_HOLD;
                    hold_cnt <= HW'(RST_HOLD);
                    evt_idx  <= '0;
                    rst_q    <= 1'b1;
                    done_q   <= 1'b0;
                end
                S_HOLD: if (hold_cnt == '0) begin
                    rst_q   <= 1'b0;
                    evt_idx <= '0;
                    if (valid[0]) begin
                        state <= S_WAIT;
                        timer <= tbl[0].delay;
                    end else begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end
                end else begin
                    hold_cnt <= hold_cnt - 1'b1;
                end
                S_WAIT: if (timer == '0) begin
                    state   <= S_PULSE;
                    pulse_q <= cur.mask;
                    wcnt    <= (cur.width == '0) ? '0 : cur.width - 1'b1;
                end else begin
                    timer <= timer - 1'b1;
                end
                // The cycle that drops the pulse also starts the next wait,
                // which guarantees a low cycle between back-to-back entries.
                S_PULSE: if (wcnt == '0) begin
                    pulse_q <= '0;
                    if (seq_end) begin
`ifdef SEQ_LOOP_EN
                        state   <= S_WAIT;
                        evt_idx <= '0;
                        timer   <= tbl[0].delay;
                        done_q  <= 1'b1;
`else
                        state  <= S_DONE;
                        done_q <= 1'b1;
`endif
                    end else begin
                        state   <= S_WAIT;
                        evt_idx <= nxt_idx;
                        timer   <= nxt.delay;
                    end
                end else begin
                    wcnt <= wcnt - 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.agc_clock = clk_q;
    assign bus.agc_rst   = rst_q;
    assign bus.pulse     = pulse_q;
    assign bus.busy      = busy;
    assign bus.done      = done_q;
    assign bus.evt_idx   = evt_idx;
endmodule

// File: tb/tb_agc_stim_seq.sv
// Randomized bench for agc_stim_seq: a timeline model derives the expected
// outputs for every cycle of a sequence from the table contents.
module tb_agc_stim_seq;
    localparam int NCH = 4, DEPTH = 8, TW = 24, WW = 8, CLKDIV = 12, RST_HOLD = 250;
    localparam int AW   = $clog2(DEPTH);
    localparam int MAXC = 1400;
`ifdef SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    typedef struct packed {
        logic           busy;
        logic           done;
        logic           rst;
        logic [AW-1:0]  idx;
        logic [NCH-1:0] pulse;
    } obs_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   edge_n = 0;
    int   rel_edge = 0;
    int   errs = 0;
    int   checks = 0;

    agc_stim_seq_if #(.NCH(NCH), .DEPTH(DEPTH), .TW(TW), .WW(WW)) bus();

    agc_stim_seq #(
        .NCH(NCH), .DEPTH(DEPTH), .TW(TW), .WW(WW), .CLKDIV(CLKDIV), .RST_HOLD(RST_HOLD)
    ) dut (
        .SIM_CLK  (clk),
        .SIM_RST_n(rst_n),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    int   m_delay [DEPTH];
    int   m_mask  [DEPTH];
    int   m_width [DEPTH];
    bit   m_last  [DEPTH];
    bit   m_valid [DEPTH];
    obs_t exp_q   [MAXC];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic obs_t mk(input bit b, input bit d, input bit r, input int i, input int p);
        obs_t o;
        o.busy = b; o.done = d; o.rst = r; o.idx = AW'(i); o.pulse = NCH'(p);
        return o;
    endfunction

    function automatic void fill(input int a, input int b, input obs_t v);
        for (int k = a; k < b && k < MAXC; k++) exp_q[k] = v;
    endfunction

    // Index k = outputs just after the k-th edge counted from the edge that samples start.
    function automatic int build(input int abort_at);
        int t, i, w, p, passes, endk;
        bit wrapped;
        fill(0, MAXC, mk(1, 0, 1, 0, 0));
        t = RST_HOLD + 1; endk = MAXC; i = 0; passes = 0; wrapped = 0;
        if (!m_valid[0]) begin
            fill(t, MAXC, mk(0, 1, 0, 0, 0));
            endk = t;
        end else begin
            while (t < MAXC) begin
                fill(t, MAXC, mk(1, 0, 0, i, 0));
                if (wrapped) exp_q[t].done = 1'b1;
                wrapped = 0;
                p = t + m_delay[i] + 1;
                w = (m_width[i] == 0) ? 1 : m_width[i];
                fill(p, p + w, mk(1, 0, 0, i, m_mask[i]));
                t = p + w;
                if (m_last[i] || i == DEPTH - 1 || !m_valid[(i + 1) % DEPTH]) begin
                    if (!LOOP) begin
                        fill(t, MAXC, mk(0, 1, 0, i, 0));
                        endk = t;
                        break;
                    end
                    passes++;
                    if (passes == 3) endk = t;
                    i = 0;
                    wrapped = 1;
                end else begin
                    i++;
                end
            end
        end
        if (abort_at >= 0) fill(abort_at, MAXC, mk(0, 0, 1, 0, 0));
        return endk;
    endfunction

    task automatic wr(input int a, input int d, input int m, input int w, input bit l);
        @(negedge clk);
        bus.wr_en = 1'b1; bus.wr_addr = AW'(a); bus.wr_delay = TW'(d);
        bus.wr_mask = NCH'(m); bus.wr_width = WW'(w); bus.wr_last = l;
        @(negedge clk);
        bus.wr_en = 1'b0;
        m_delay[a] = d; m_mask[a] = m; m_width[a] = w; m_last[a] = l; m_valid[a] = 1'b1;
    endtask

    // abort_at: edge at which abort (plus a competing start) is sampled; st_at: a
    // start offered mid-sequence; ws_at: a write to entry 3 offered while busy.
    task automatic run_seq(input string tag, input int abort_at, input int st_at, input int ws_at);
        int endk, ncyc, ab, n;
        obs_t o;
        ab = abort_at;
        endk = build(-1);
        if (LOOP && ab < 0) ab = endk + 2;
        endk = build(ab);
        ncyc = endk + 6;
        if (ab >= 0 && ab + 4 > ncyc) ncyc = ab + 4;
        if (ncyc > MAXC) ncyc = MAXC;
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = (ab == 0);
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            bus.start = 1'b0; bus.abort = 1'b0; bus.wr_en = 1'b0;
            o.busy = bus.busy; o.done = bus.done; o.rst = bus.agc_rst;
            o.idx = bus.evt_idx; o.pulse = bus.pulse;
            n = edge_n - rel_edge;
            chk({tag, "/aclk"}, 32'(bus.agc_clock), 32'(((n - 2) / CLKDIV) % 2));
            chk(tag, 32'(o), 32'(exp_q[k]));
            if (k + 1 == ab) begin bus.abort = 1'b1; bus.start = 1'b1; end
            if (k + 1 == st_at && exp_q[k].busy) bus.start = 1'b1;
            if (k + 1 == ws_at && exp_q[k].busy) begin
                bus.wr_en = 1'b1; bus.wr_addr = AW'(3);
                bus.wr_delay = TW'($urandom_range(0, 60));
                bus.wr_mask = NCH'($urandom_range(1, 15));
                bus.wr_width = WW'($urandom_range(1, 9));
                bus.wr_last = 1'b0;
            end
        end
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0; bus.wr_en = 1'b0;
    endtask

    initial begin
        int k, ab, n;
        bus.start = 0; bus.abort = 0; bus.wr_en = 0; bus.wr_addr = '0;
        bus.wr_delay = '0; bus.wr_mask = '0; bus.wr_width = '0; bus.wr_last = 0;
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst/aclk",  32'(bus.agc_clock), 32'd0);
        chk("rst/arst",  32'(bus.agc_rst),   32'd1);
        chk("rst/pulse", 32'(bus.pulse),     32'd0);
        chk("rst/busy",  32'(bus.busy),      32'd0);
        chk("rst/done",  32'(bus.done),      32'd0);
        chk("rst/idx",   32'(bus.evt_idx),   32'd0);

        // Internal release lands two edges after the external deassertion.
        rst_n = 1'b1;
        rel_edge = edge_n;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            n = (c < 2) ? 0 : ((c - 2) / CLKDIV) % 2;
            chk("div/aclk", 32'(bus.agc_clock), 32'(n));
            chk("div/arst", 32'(bus.agc_rst), 32'd1);
        end

        wr(0, 100, 4'b0001, 5, 1'b1);
        run_seq("single", -1, RST_HOLD + 40, -1);

        wr(0, 0, $urandom_range(1, 15), 0, 1'b0);
        wr(1, 10, $urandom_range(1, 15), 3, 1'b0);
        wr(2, 4, $urandom_range(1, 15), 2, 1'b1);
        run_seq("three", -1, -1, -1);

        k = build(-1);
        ab = -1;
        for (int c = 0; c < MAXC; c++)
            if (ab < 0 && exp_q[c].idx == AW'(1) && exp_q[c].pulse != '0) ab = c + 1;
        run_seq("abort", ab, -1, -1);

        wr(2, 4, $urandom_range(1, 15), 2, 1'b0);
        wr(3, 7, 4'b1010, 4, 1'b1);
        run_seq("busywr", -1, -1, RST_HOLD + 20);
        run_seq("rerun", -1, -1, -1);

        wr(0, 3, 4'b0110, 2, 1'b0);
        wr(1, 5, 4'b1001, 1, 1'b1);
        run_seq("two", -1, -1, -1);

        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, DEPTH);
            for (int a = 0; a < n; a++)
                wr(a, $urandom_range(0, 30), $urandom_range(0, 15), $urandom_range(0, 5),
                   (a == n - 1) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 5) == 0));
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 500) : -1;
            run_seq("rand", ab, $urandom_range(1, 400), $urandom_range(1, 400));
        end

        wr(0, 50, 4'b0011, 2, 1'b1);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (RST_HOLD + 20) @(negedge clk);
        chk("mid/busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid/aclk",  32'(bus.agc_clock), 32'd0);
        chk("mid/arst",  32'(bus.agc_rst),   32'd1);
        chk("mid/pulse", 32'(bus.pulse),     32'd0);
        chk("mid/busy0", 32'(bus.busy),      32'd0);
        chk("mid/done",  32'(bus.done),      32'd0);
        chk("mid/idx",   32'(bus.evt_idx),   32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
